mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the multicycle controller's memory bus (mem_addr / mem_write_en / mem_write_data / mem_data).
//  Holds the unified instruction/data word RAM, a memory-mapped console TX FIFO and a free-running cycle counter.
//  The controller drives the bus combinationally and samples mem_data on negedge clk; this block acts on posedge clk.
// PARAMETERS
//  RAM_AW     10              RAM word-address width; the RAM holds 2**RAM_AW words at byte address 0.
//  FIFO_DEPTH 8               TX FIFO entries; must be a power of 2, at least 2.
//  MMIO_BASE  32'hFFFF_0000   Base byte address of the MMIO window.
//  INIT_FILE  ""              If non-empty, RAM is preloaded with $readmemh at elaboration.
// PORTS
//  clk             in   1   System clock; all state updates on posedge.
//  reset           in   1   Synchronous reset, active-high.
//  mem_addr        in   32  Byte address from the controller.
//  mem_write_en    in   1   Write strobe; the write commits on the posedge clk where it is high.
//  mem_write_data  in   32  Write data; the controller has already merged bytes and halfwords.
//  mem_data        out  32  Read data, registered.
//  tx_data         out  8   Console byte at the FIFO head.
//  tx_valid        out  1   FIFO not empty.
//  tx_ready        in   1   Sink accepts tx_data on a posedge where tx_valid && tx_ready.
//  bus_err         out  1   Sticky error flag; cleared only by reset.
// BEHAVIOUR
//  - Reset values: mem_data=0, tx_valid=0, tx_data=0, bus_err=0, FIFO empty, cycle counter=0, overflow bit=0. RAM contents are not cleared.
//  - Decode (byte address A):
//      RAM:      A < 4*2**RAM_AW. Word index A[RAM_AW+1:2].
//      MMIO:     A >= MMIO_BASE.
//      Unmapped: any other address.
//  - Read latency: on each posedge, mem_data <= word(mem_addr), whether or not a write occurs.
//      Data is valid at the following negedge (half a cycle).
//      If a read and a write hit the same word on one edge, mem_data returns the OLD word (read-before-write).
//  - RAM write: on posedge with mem_write_en, the RAM word is written with mem_write_data.
//      A[1:0] is ignored for both reads and writes.
//      A[1:0]!=0 together with mem_write_en sets bus_err; the write still commits to the aligned word.
//  - MMIO map (offsets from MMIO_BASE):
//      +0x0 TXDATA: write pushes mem_write_data[7:0]; read returns 0.
//      +0x4 STATUS (read-only): bit0 full, bit1 empty, bit2 overflow (sticky), bits[15:8] count, all other bits 0.
//      +0x8 CYCLES (read-only): 32-bit counter, +1 every posedge out of reset, wraps 0xFFFFFFFF->0; reads return the pre-edge value.
//      Any other MMIO offset: read 0; a write is ignored and sets bus_err. A write to STATUS or CYCLES is ignored and sets bus_err.
//  - Unmapped: read returns 0; a write is ignored and sets bus_err. A read alone does not set bus_err.
//  - TX FIFO:
//      Push when TXDATA is written; pop when tx_valid && tx_ready.
//      Push while full and no pop in the same edge: byte dropped, overflow set, bus_err not set.
//      Simultaneous push+pop when full: both happen; count unchanged; no overflow.
//      Simultaneous push+pop when empty: only the push happens; the pop is not possible since tx_valid=0.
//      tx_data/tx_valid are registered FIFO head/non-empty flags: a pushed byte is visible the posedge after the push.
//      Read and write pointers wrap modulo FIFO_DEPTH.
//      count is 0..FIFO_DEPTH, zero-extended into STATUS bits[15:8].
//  - Reset asserted mid-operation: any write on that edge is discarded, the FIFO is flushed, and counter and flags return to their reset values.
// STRUCTURE
//  - Shared header mem_map.vh: MMIO_BASE default, offsets TXDATA_OFF=0x0, STATUS_OFF=0x4, CYCLES_OFF=0x8, and STATUS bit positions.
//  - Sub-module tx_fifo (parameter DEPTH; ports push/din/full, pop/dout/empty, count): a synchronous circular buffer.
//  - Top level: address decode, RAM array, read-data mux/register, cycle counter, bus_err logic.
// TESTING
//  1. Write 0xDEADBEEF to 0x10; read 0x10 on the next cycle -> mem_data=0xDEADBEEF at the next negedge. Same-edge read and write to 0x10 -> old value returned.
//  2. Hold tx_ready=0; write 0x41..0x48 to TXDATA -> STATUS=0x0000_0801. A 9th write -> STATUS bit2 set, count still 8, bus_err=0.
//  3. With the FIFO full, push and pop on the same edge -> count stays 8, no overflow. Drain -> bytes 0x42..0x48, then the pushed byte, in order.
//  4. Write to 0x8000_0000 -> bus_err=1, and a read of 0x8000_0000 returns 0. Write to 0x12 -> bus_err=1, word at 0x10 is updated.
//  5. Read CYCLES 5 edges apart -> difference 5. Force the counter to 0xFFFFFFFF -> next read returns 0.
//  6. Assert reset with 3 bytes queued and a write pending -> tx_valid=0, STATUS=0x0000_0002, the pending write is absent, bus_err=0.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared memory-map constants and STATUS packing for the memory responder.
// Imported by the top level and its TX FIFO.
package mem_responder_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

    localparam logic [31:0] TXDATA_OFF = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFF = 32'h0000_0004;
    localparam logic [31:0] CYCLES_OFF = 32'h0000_0008;

    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_MMIO,
        REGION_UNMAPPED
    } region_e;

    function automatic logic [31:0] status_word(input logic       full,
                                                input logic       empty,
                                                input logic       ovf,
                                                input logic [7:0] count);
        logic [31:0] w;
        w                           = '0;
        w[STATUS_FULL_BIT]          = full;
        w[STATUS_EMPTY_BIT]         = empty;
        w[STATUS_OVF_BIT]           = ovf;
        w[STATUS_COUNT_LSB +: 8]    = count;
        return w;
    endfunction

endpackage

// File: rtl/mem_responder_tx_fifo.sv
// Console TX FIFO: synchronous circular buffer whose head byte and empty
// flag are registered, so a pushed byte appears one edge after the push.
module tx_fifo #(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    din,
    output logic          full,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_dout;
    logic          r_empty;

    logic          w_pop_ok;
    logic          w_push_ok;
    logic [AW-1:0] w_rd_next;
    logic [CW-1:0] w_count_next;

    assign full         = (r_count == CW'(DEPTH));
    assign w_pop_ok     = pop && !r_empty;
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign w_push_ok    = push && (!full || w_pop_ok);
    assign w_rd_next    = r_rd + AW'(1);
    assign w_count_next = r_count + {{(CW-1){1'b0}}, w_push_ok}
                                  - {{(CW-1){1'b0}}, w_pop_ok};

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_dout  <= '0;
            r_empty <= 1'b1;
        end else begin
            if (w_pop_ok)  r_rd <= w_rd_next;
            if (w_push_ok) r_wr <= r_wr + AW'(1);
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            if (w_push_ok && (r_empty || (w_pop_ok && r_count == CW'(1))))
                r_dout <= din;
            else if (w_pop_ok)
                r_dout <= r_mem[w_rd_next];
        end
    end

    // NOTE: storage arrays get no reset; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr] <= din;
    end

    assign dout  = r_dout;
    assign empty = r_empty;
    assign count = r_count;

endmodule

// File: rtl/mem_responder.sv
// Memory-side bus responder: word RAM, console TX FIFO and cycle counter
// behind one registered read port, with a sticky bus error flag.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int          RAM_AW     = 10,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
    parameter string       INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic        mem_write_en,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_err
);

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [32:0] RAM_BYTES = 33'(4 * (2 ** RAM_AW));

    logic [31:0] r_ram [2**RAM_AW];
    logic [31:0] r_cycles;
    logic        r_overflow;

    region_e     w_region;
    logic [31:0] w_off;
    logic [RAM_AW-1:0] w_idx;
    logic [31:0] w_rdata;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_dout;
    logic [CW-1:0] w_count;
    logic        w_err_write;

    assign w_off = mem_addr - MMIO_BASE;
    assign w_idx = mem_addr[RAM_AW+1:2];

    // NOTE: always_comb assigns every output a default first, so no path infers a latch.
    always_comb begin
        w_region = REGION_UNMAPPED;
        if ({1'b0, mem_addr} < RAM_BYTES)
            w_region = REGION_RAM;
        else if (mem_addr >= MMIO_BASE)
            w_region = REGION_MMIO;
    end

    assign w_push = mem_write_en && (w_region == REGION_MMIO) && (w_off == TXDATA_OFF);
    assign w_pop  = tx_valid && tx_ready;

    tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   (mem_write_data[7:0]),
        .full  (w_full),
        .pop   (w_pop),
        .dout  (w_dout),
        .empty (w_empty),
        .count (w_count)
    );

    assign tx_valid = !w_empty;
    assign tx_data  = w_dout;

    always_comb begin
        w_rdata = '0;
        case (w_region)
            REGION_RAM:  w_rdata = r_ram[w_idx];
            REGION_MMIO: begin
                if (w_off == STATUS_OFF)
                    w_rdata = status_word(w_full, w_empty, r_overflow, 8'(w_count));
                else if (w_off == CYCLES_OFF)
                    w_rdata = r_cycles;
            end
            default:     w_rdata = '0;
        endcase
    end

    // Misaligned RAM writes still commit; every other non-TXDATA write is dropped.
    always_comb begin
        w_err_write = 1'b0;
        if (mem_write_en) begin
            case (w_region)
                REGION_RAM:  w_err_write = (mem_addr[1:0] != 2'b00);
                REGION_MMIO: w_err_write = (w_off != TXDATA_OFF);
                default:     w_err_write = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_data   <= '0;
            r_cycles   <= '0;
            r_overflow <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            mem_data <= w_rdata;
            r_cycles <= r_cycles + 32'd1;
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            if (w_err_write)                bus_err    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && mem_write_en && (w_region == REGION_RAM))
            r_ram[w_idx] <= mem_write_data;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed and randomized bench for mem_responder, compared every cycle
// against a queue/array model of the memory map.
module tb_mem_responder;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam logic [31:0] TXD  = BASE;
    localparam logic [31:0] STA  = BASE + 32'h4;
    localparam logic [31:0] CYC  = BASE + 32'h8;
    localparam int          WORDS = 1024;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_addr = '0;
    logic        mem_write_en = 1'b0;
    logic [31:0] mem_write_data = '0;
    logic        tx_ready = 1'b0;
    logic [31:0] mem_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        bus_err;

    mem_responder dut (
        .clk            (clk),
        .reset          (reset),
        .mem_addr       (mem_addr),
        .mem_write_en   (mem_write_en),
        .mem_write_data (mem_write_data),
        .mem_data       (mem_data),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .bus_err        (bus_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_ram    [WORDS];
    bit          m_ram_ok [WORDS];
    logic [7:0]  m_fifo [$];
    bit          m_ovf;
    bit          m_berr;
    logic [31:0] m_cyc;
    logic [31:0] m_rdata;
    bit          m_known;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {16'h0, 8'(m_fifo.size()), 5'h0, m_ovf,
                (m_fifo.size() == 0), (m_fifo.size() == DEPTH)};
    endfunction

    // One bus cycle: drive at negedge, model the posedge, compare at the next negedge.
    task automatic step(input logic rst, input logic [31:0] a, input logic we,
                        input logic [31:0] wd, input logic rdy);
        int  idx;
        bit  pop;
        bit  push;
        reset          = rst;
        mem_addr       = a;
        mem_write_en   = we;
        mem_write_data = wd;
        tx_ready       = rdy;
        @(posedge clk);
        idx = int'(a[11:2]);
        if (rst) begin
            m_rdata = '0;
            m_known = 1'b1;
            m_fifo.delete();
            m_ovf   = 1'b0;
            m_berr  = 1'b0;
            m_cyc   = '0;
        end else begin
            m_known = 1'b1;
            m_rdata = '0;
            if (a < 32'(4 * WORDS)) begin
                m_rdata = m_ram[idx];
                m_known = m_ram_ok[idx];
            end else if (a >= BASE) begin
                if (a == STA)      m_rdata = m_status();
                else if (a == CYC) m_rdata = m_cyc;
            end
            pop  = (m_fifo.size() != 0) && rdy;
            push = we && (a == TXD);
            if (we) begin
                if (a < 32'(4 * WORDS)) begin
                    m_ram[idx]    = wd;
                    m_ram_ok[idx] = 1'b1;
                    if (a[1:0] != 2'b00) m_berr = 1'b1;
                end else if (a != TXD) begin
                    m_berr = 1'b1;
                end
            end
            if (pop) void'(m_fifo.pop_front());
            if (push) begin
                if (m_fifo.size() == DEPTH) m_ovf = 1'b1;
                else                        m_fifo.push_back(wd[7:0]);
            end
            m_cyc = m_cyc + 32'd1;
        end
        @(negedge clk);
        if (m_known) check("mem_data", mem_data, m_rdata);
        check("tx_valid", 32'(tx_valid), 32'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) check("tx_data", 32'(tx_data), 32'(m_fifo[0]));
        else if (rst)           check("tx_data_rst", 32'(tx_data), 32'h0);
        check("bus_err", 32'(bus_err), 32'(m_berr));
    endtask

    logic [7:0]  drain_exp [8] = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h50};
    logic [31:0] v1;
    logic [31:0] v2;
    int          op;
    logic [31:0] ra;
    logic        rwe;
    logic [31:0] rwd;
    logic        rrdy;
    logic        rrst;

    initial begin : main
        for (int i = 0; i < WORDS; i++) m_ram_ok[i] = 1'b0;

        step(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        check("reset_mem_data", mem_data, 32'h0);
        check("reset_tx_valid", 32'(tx_valid), 32'h0);
        check("reset_bus_err", 32'(bus_err), 32'h0);

        for (int i = 0; i < 16; i++) step(1'b0, 32'(i) << 2, 1'b1, $urandom, 1'b0);

        // Basic write/read, then read-before-write on the same word.
        step(1'b0, 32'h10, 1'b1, 32'hDEAD_BEEF, 1'b0);
        step(1'b0, 32'h10, 1'b0, 32'h0, 1'b0);
        check("rd_after_wr", mem_data, 32'hDEAD_BEEF);
        step(1'b0, 32'h10, 1'b1, 32'h1234_5678, 1'b0);
        check("rd_before_wr", mem_data, 32'hDEAD_BEEF);
        step(1'b0, 32'h10, 1'b0, 32'h0, 1'b0);
        check("rd_new_word", mem_data, 32'h1234_5678);

        // Fill the FIFO, then overflow it.
        for (int i = 0; i < 8; i++) step(1'b0, TXD, 1'b1, 32'h41 + 32'(i), 1'b0);
        step(1'b0, STA, 1'b0, 32'h0, 1'b0);
        check("status_full", mem_data, 32'h0000_0801);
        step(1'b0, TXD, 1'b1, 32'h49, 1'b0);
        step(1'b0, STA, 1'b0, 32'h0, 1'b0);
        check("status_ovf", mem_data, 32'h0000_0805);
        check("ovf_no_bus_err", 32'(bus_err), 32'h0);

        // Push and pop on the same edge while full, then drain in order.
        step(1'b0, TXD, 1'b1, 32'h50, 1'b1);
        step(1'b0, STA, 1'b0, 32'h0, 1'b0);
        check("pushpop_count", 32'(mem_data[15:8]), 32'h8);
        for (int i = 0; i < 8; i++) begin
            check("drain_order", 32'(tx_data), 32'(drain_exp[i]));
            step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        end
        check("drained_empty", 32'(tx_valid), 32'h0);

        // Unmapped and misaligned accesses.
        step(1'b0, 32'h8000_0000, 1'b1, 32'h1234, 1'b0);
        check("unmapped_wr_err", 32'(bus_err), 32'h1);
        step(1'b0, 32'h8000_0000, 1'b0, 32'h0, 1'b0);
        check("unmapped_rd_zero", mem_data, 32'h0);
        step(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h12, 1'b1, 32'hCAFE_F00D, 1'b0);
        check("misaligned_err", 32'(bus_err), 32'h1);
        step(1'b0, 32'h10, 1'b0, 32'h0, 1'b0);
        check("misaligned_commit", mem_data, 32'hCAFE_F00D);

        // Cycle counter spacing and wrap.
        step(1'b0, CYC, 1'b0, 32'h0, 1'b0);
        v1 = mem_data;
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, CYC, 1'b0, 32'h0, 1'b0);
        v2 = mem_data;
        check("cycles_delta", v2 - v1, 32'd5);
        force dut.r_cycles = 32'hFFFF_FFFF;
        #1;
        release dut.r_cycles;
        m_cyc = 32'hFFFF_FFFF;
        step(1'b0, CYC, 1'b0, 32'h0, 1'b0);
        check("cycles_max", mem_data, 32'hFFFF_FFFF);
        step(1'b0, CYC, 1'b0, 32'h0, 1'b0);
        check("cycles_wrap", mem_data, 32'h0);

        // Reset mid-operation discards the pending write and flushes the FIFO.
        step(1'b0, 32'h20, 1'b1, 32'h1111_1111, 1'b0);
        step(1'b0, BASE + 32'hC, 1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, TXD, 1'b1, 32'h61 + 32'(i), 1'b0);
        step(1'b1, 32'h20, 1'b1, 32'hBAD0_BAD0, 1'b1);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'h0);
        step(1'b0, STA, 1'b0, 32'h0, 1'b0);
        check("rst_status", mem_data, 32'h0000_0002);
        step(1'b0, 32'h20, 1'b0, 32'h0, 1'b0);
        check("rst_write_dropped", mem_data, 32'h1111_1111);

        // Randomized traffic over the whole map.
        for (int i = 0; i < 600; i++) begin
            op   = int'($urandom_range(0, 10));
            rwd  = $urandom;
            rrdy = ($urandom_range(0, 3) == 0);
            rrst = ($urandom_range(0, 79) == 0);
            rwe  = 1'b0;
            ra   = 32'($urandom_range(0, 15)) << 2;
            case (op)
                0, 1:  rwe = 1'b0;
                2:     begin ra = ra | 32'($urandom_range(0, 3)); rwe = 1'b1; end
                3, 10: begin ra = TXD; rwe = 1'b1; end
                4:     ra = STA;
                5:     ra = CYC;
                6:     begin ra = 32'h8000_0000 | ($urandom & 32'h0000_FFFC); rwe = 1'($urandom_range(0, 1)); end
                7:     begin ra = BASE + 32'h10 + 32'($urandom_range(0, 255)); rwe = 1'($urandom_range(0, 1)); end
                8:     begin ra = ($urandom_range(0, 1) == 0) ? STA : CYC; rwe = 1'b1; end
                default: rwe = 1'b1;
            endcase
            step(rrst, ra, rwe, rwd, rrdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
